mem_access_ctrl: RTL

Initiator side of the MEM-stage data-memory interface. Converts one 16-bit load or store from the EX/MEM pipeline register into two sequential byte transactions on a byte-wide, variable-latency memory port. Byte order is big-endian: high byte at `address`, low byte at `address+1`. Stalls the pipeline until both bytes complete, then returns the assembled load data.

---
 rtl/mem_if_pkg.sv | 14 +
 rtl/mem_access_ctrl_if.sv | 32 +++
 rtl/mem_access_ctrl.sv | 84 ++++++++
 3 files changed

// File: rtl/mem_if_pkg.sv
// Shared definitions for the MEM-stage data-memory interface.
// Holds the FSM state encoding and the default address width.
package mem_if_pkg;

  localparam int DEF_ADDR_W = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HI   = 2'd1,
    S_LO   = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Byte-wide, variable-latency data-memory port between the MEM-stage initiator and memory.
// Handshake: a byte completes on any rising edge where mem_req and mem_ack are both 1; while mem_req=1 and mem_ack=0 the initiator holds mem_addr/mem_we/mem_wdata stable, mem_rdata is valid only in the mem_ack cycle, and mem_ack with mem_req=0 is ignored.
interface mem_access_ctrl_if #(
  parameter int ADDR_W = mem_if_pkg::DEF_ADDR_W
) ();

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_ack;
  logic [7:0]        mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_ack,
    output mem_rdata
  );

endinterface

// File: rtl/mem_access_ctrl.sv
// Splits one 16-bit load/store into two big-endian byte transactions (high byte at address,
// low byte at address+1) and stalls the pipeline until both bytes have completed.
module mem_access_ctrl
  import mem_if_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] address,
  input  logic [15:0]       write_data,
  output logic              stall,
  output logic              done,
  output logic [15:0]       read_data,
  output state_t            dbg_state,
  mem_access_ctrl_if.master mem
);

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wdata_q;
  logic              we_q;

  // Only the IDLE term looks at live inputs; everything else comes from registers.
  assign stall     = ((state == S_IDLE) && (MemRead || MemWrite)) ||
                     (state == S_HI) || (state == S_LO);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      we_q          <= 1'b0;
      done          <= 1'b0;
      read_data     <= '0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (MemRead || MemWrite) begin
            // A store wins when both are requested; the load is dropped.
            addr_q        <= address;
            wdata_q       <= write_data;
            we_q          <= MemWrite;
            mem.mem_req   <= 1'b1;
            mem.mem_we    <= MemWrite;
            mem.mem_addr  <= address;
            mem.mem_wdata <= write_data[15:8];
            state         <= S_HI;
          end
        end
        S_HI: begin
          if (mem.mem_ack) begin
            if (!we_q) read_data[15:8] <= mem.mem_rdata;
            mem.mem_addr  <= addr_q + ADDR_W'(1);
            mem.mem_wdata <= wdata_q[7:0];
            state         <= S_LO;
          end
        end
        S_LO: begin
          if (mem.mem_ack) begin
            if (!we_q) read_data[7:0] <= mem.mem_rdata;
            mem.mem_req <= 1'b0;
            mem.mem_we  <= 1'b0;
            done        <= 1'b1;
            state       <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
